// File: rtl/pca_pkg.sv
// Shared definitions for pipelined_carry_adder: stage-count helper, parameter
// legality check and the stage valid vector type.
package pca_pkg;

  localparam int MAX_STAGES = 64;

  // Sized for the deepest legal pipeline; unused upper bits stay at zero.
  typedef logic [MAX_STAGES-1:0] stage_valid_t;

  function automatic int stages(input int width, input int seg);
    return width / seg;
  endfunction

  function automatic bit params_ok(input int width, input int seg);
    return (seg > 0) && (width >= seg) && ((width % seg) == 0) &&
           ((width / seg) <= MAX_STAGES);
  endfunction

endpackage

// File: rtl/pca_seg_adder.sv
// SEG-bit combinational ripple-carry segment built from full-adder cells.
module pca_seg_adder
  import pca_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  logic [SEG:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co = c[SEG];

endmodule

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit adder split into WIDTH/SEG registered ripple segments with valid/ready
// backpressure. Define PIPELINED_CARRY_ADDER_SUB_EN to add a per-request sub port.
module pipelined_carry_adder
  import pca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int STAGES = stages(WIDTH, SEG);

  if (!params_ok(WIDTH, SEG)) begin : g_bad_params
    $fatal(1, "pipelined_carry_adder: WIDTH must be a positive multiple of SEG");
  end

  stage_valid_t                 valid_q, valid_d;
  logic [STAGES-1:0]            adv;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d, a_q, a_d, b_q, b_d;
  logic [STAGES-1:0]            c_q, c_d, sub_q, sub_d;

  logic [STAGES-1:0][WIDTH-1:0] stage_a, stage_b, stage_sum;
  logic [STAGES-1:0]            stage_c, stage_v, stage_sub;
  logic [STAGES-1:0][SEG-1:0]   seg_x, seg_y, seg_s;
  logic [STAGES-1:0]            seg_ci, seg_co;
  logic                         sub_in;
  logic                         unused_bits;

`ifdef PIPELINED_CARRY_ADDER_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Stage k is fed by the input ports (k == 0) or by the registers of stage k-1.
  always_comb begin
    stage_a   = '0;
    stage_b   = '0;
    stage_sum = '0;
    stage_c   = '0;
    stage_v   = '0;
    stage_sub = '0;
    seg_x     = '0;
    seg_y     = '0;
    seg_ci    = '0;
    stage_a[0]   = a;
    stage_b[0]   = b;
    stage_c[0]   = sub_in ? 1'b1 : cin;
    stage_v[0]   = in_valid;
    stage_sub[0] = sub_in;
    for (int k = 1; k < STAGES; k++) begin
      stage_a[k]   = a_q[k-1];
      stage_b[k]   = b_q[k-1];
      stage_sum[k] = sum_q[k-1];
      stage_c[k]   = c_q[k-1];
      stage_v[k]   = valid_q[k-1];
      stage_sub[k] = sub_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_x[k]  = stage_a[k][k*SEG +: SEG];
      seg_y[k]  = stage_b[k][k*SEG +: SEG] ^ {SEG{stage_sub[k]}};
      seg_ci[k] = stage_c[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pca_seg_adder #(.SEG(SEG)) u_seg (
      .x  (seg_x[k]),
      .y  (seg_y[k]),
      .ci (seg_ci[k]),
      .s  (seg_s[k]),
      .co (seg_co[k])
    );
  end

  // A stage may take new contents when it is empty or its successor is moving on.
  always_comb begin
    adv           = '0;
    adv[STAGES-1] = !valid_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !valid_q[k] || adv[k+1];
    end
  end

  // Consumed slices of a/b are zeroed so only the unprocessed skew bits remain live.
  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    for (int k = 0; k < STAGES; k++) begin
      if (adv[k]) begin
        valid_d[k] = stage_v[k];
        if (stage_v[k]) begin
          sum_d[k]                = stage_sum[k];
          sum_d[k][k*SEG +: SEG]  = seg_s[k];
          c_d[k]                  = seg_co[k];
          a_d[k]                  = stage_a[k] & ({WIDTH{1'b1}} << ((k + 1) * SEG));
          b_d[k]                  = stage_b[k] & ({WIDTH{1'b1}} << ((k + 1) * SEG));
          sub_d[k]                = stage_sub[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      sum_q   <= '0;
      c_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
    end
  end

  assign in_ready  = !valid_q[0] || adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = c_q[STAGES-1];

  assign unused_bits = ^{valid_q, a_q[STAGES-1], b_q[STAGES-1], sub_q[STAGES-1]};

endmodule
